// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter2
//  Description : Two-master round-robin arbiter for one pipelined Wishbone
//                slave. Grants whole CYC cycles, routes ACK/data to the
//                owner, counts in-flight requests and drains them when the
//                owner drops CYC early.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter2 #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MAX_OUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack,
    output logic          m0_stall,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack,
    output logic          m1_stall,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack,
    input  logic          s_stall
);

    localparam int                c_cnt_w = $clog2(MAX_OUT) + 1;
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_OUT);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_g0    = 2'd1;
    localparam logic [1:0] c_g1    = 2'd2;
    localparam logic [1:0] c_drain = 2'd3;

    logic [1:0]         r_state;
    logic               r_last;
    logic [c_cnt_w-1:0] r_cnt;
    logic [DW-1:0]      r_m0_dat;
    logic [DW-1:0]      r_m1_dat;

    logic w_full;
    logic w_accept;
    logic w_ack_valid;
    logic w_last_ack;
    logic w_own_cyc;

    assign w_full      = (r_cnt == c_max);
    assign w_accept    = s_stb & ~s_stall;
    // An ACK with nothing outstanding is a slave error and must not underflow
    assign w_ack_valid = s_ack & (r_cnt != '0);
    assign w_last_ack  = s_ack & (r_cnt == c_one);
    assign w_own_cyc   = (r_state == c_g1) ? m1_cyc : m0_cyc;

    // Route the granted master onto the slave; everyone else is held off
    always_comb begin
        s_cyc    = (r_state == c_drain);
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_o  = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_stall = 1'b1;
        m1_stall = 1'b1;
        m0_dat_o = r_m0_dat;
        m1_dat_o = r_m1_dat;
        case (r_state)
            c_g0: begin
                // CYC stays up on the abort cycle while requests are in flight
                s_cyc    = m0_cyc | (r_cnt != '0);
                s_stb    = m0_cyc & m0_stb & ~w_full;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_o  = m0_dat_i;
                m0_stall = s_stall | w_full;
                m0_ack   = s_ack;
                m0_dat_o = s_dat_i;
            end
            c_g1: begin
                s_cyc    = m1_cyc | (r_cnt != '0);
                s_stb    = m1_cyc & m1_stb & ~w_full;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_o  = m1_dat_i;
                m1_stall = s_stall | w_full;
                m1_ack   = s_ack;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

    // Grant FSM, outstanding-request counter and per-master read-data hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_last   <= 1'b1;
            r_cnt    <= '0;
            r_m0_dat <= '0;
            r_m1_dat <= '0;
        end else begin
            if (w_accept && !w_ack_valid) begin
                r_cnt <= r_cnt + c_one;
            end else if (!w_accept && w_ack_valid) begin
                r_cnt <= r_cnt - c_one;
            end

            if (r_state == c_g0) begin
                r_m0_dat <= s_dat_i;
            end
            if (r_state == c_g1) begin
                r_m1_dat <= s_dat_i;
            end

            case (r_state)
                c_idle: begin
                    // Tie goes to whichever master did not win last time
                    if (m0_cyc && (!m1_cyc || r_last)) begin
                        r_state <= c_g0;
                        r_last  <= 1'b0;
                    end else if (m1_cyc) begin
                        r_state <= c_g1;
                        r_last  <= 1'b1;
                    end
                end
                c_g0, c_g1: begin
                    if (!w_own_cyc) begin
                        r_state <= ((r_cnt == '0) || w_last_ack) ? c_idle : c_drain;
                    end
                end
                c_drain: begin
                    if ((r_cnt == '0) || w_last_ack) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // Flag slave ACKs that arrive with nothing outstanding
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(s_ack && (r_cnt == '0)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter2
//  Description : Randomized bench for wb_arbiter2 with a behavioural
//                arbiter/slave reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

    localparam int MAX_OUT = 2;

    typedef struct packed {
        logic        we;
        logic [15:0] adr;
        logic [15:0] dat;
    } req_t;

    logic        clk;
    logic        rst;
    logic        m_cyc   [2];
    logic        m_stb   [2];
    logic        m_we    [2];
    logic [15:0] m_adr   [2];
    logic [15:0] m_dati  [2];
    logic [15:0] m_dato  [2];
    logic        m_ack   [2];
    logic        m_stall [2];
    logic        s_cyc, s_stb, s_we, s_ack, s_stall;
    logic [15:0] s_adr, s_dat_o, s_dat_i;

    wb_arbiter2 #(.AW(16), .DW(16), .MAX_OUT(MAX_OUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_cyc   (m_cyc[0]),
        .m0_stb   (m_stb[0]),
        .m0_we    (m_we[0]),
        .m0_adr   (m_adr[0]),
        .m0_dat_i (m_dati[0]),
        .m0_dat_o (m_dato[0]),
        .m0_ack   (m_ack[0]),
        .m0_stall (m_stall[0]),
        .m1_cyc   (m_cyc[1]),
        .m1_stb   (m_stb[1]),
        .m1_we    (m_we[1]),
        .m1_adr   (m_adr[1]),
        .m1_dat_i (m_dati[1]),
        .m1_dat_o (m_dato[1]),
        .m1_ack   (m_ack[1]),
        .m1_stall (m_stall[1]),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_adr    (s_adr),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack    (s_ack),
        .s_stall  (s_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: who owns the bus, whether a drain is in progress
    int          owner;
    bit          draining;
    bit          last;
    logic [15:0] hold [2];
    req_t        q[$];
    logic [15:0] mem [0:65535];

    int stall_pct, ack_pct;
    bit rand_mode;

    // master agents
    int          a_tx[2], a_burst[2], a_iss[2], a_ackd[2], a_abort[2];
    bit          a_gap[2], a_wr[2];
    logic [15:0] a_base[2];
    bit          g_acc[2], g_ack[2];

    // observations
    int          ack_cnt[2];
    logic [15:0] last_ack_dat[2];
    int          ack_log[$];

    function automatic logic [15:0] rom_f(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int n, input int tx, input int burst,
                         input logic [15:0] base, input bit wr, input int abort_at);
        a_tx[n] = tx; a_burst[n] = burst; a_base[n] = base; a_wr[n] = wr;
        a_abort[n] = abort_at; a_iss[n] = 0; a_ackd[n] = 0; a_gap[n] = 1'b0;
    endtask

    task automatic drive_agents();
        for (int n = 0; n < 2; n++) begin
            if (a_tx[n] > 0 && !a_gap[n]) begin
                m_cyc[n]  = 1'b1;
                m_stb[n]  = (a_iss[n] < a_burst[n]);
                m_adr[n]  = a_base[n] + 16'(a_iss[n]);
                m_we[n]   = a_wr[n];
                m_dati[n] = 16'($urandom);
            end else begin
                m_cyc[n] = 1'b0; m_stb[n] = 1'b0; m_we[n] = 1'b0;
                m_adr[n] = 16'h0; m_dati[n] = 16'h0;
            end
        end
    endtask

    task automatic update_agents();
        for (int n = 0; n < 2; n++) begin
            if (m_cyc[n]) begin
                if (g_acc[n]) a_iss[n]++;
                if (g_ack[n]) a_ackd[n]++;
                if ((a_iss[n] == a_burst[n] && a_ackd[n] >= a_iss[n]) ||
                    (a_abort[n] > 0 && a_iss[n] >= a_abort[n])) begin
                    a_tx[n]--; a_gap[n] = 1'b1; a_iss[n] = 0; a_ackd[n] = 0;
                end
            end else begin
                a_gap[n] = 1'b0;
            end
        end
    endtask

    // One clock: slave responds, outputs checked at negedge, model advanced
    task automatic cycle();
        logic        e_cyc, e_stb, e_we;
        logic [15:0] e_adr, e_dat;
        logic        e_ack[2], e_stl[2];
        logic [15:0] e_do[2];
        bit          full, acc, sv_rst, sv_ack;
        logic [15:0] sv_dat;
        req_t        r;
        int          left;

        s_stall = ($urandom_range(99) < stall_pct);
        s_ack   = !rst && (q.size() > 0) && ($urandom_range(99) < ack_pct);
        if (s_ack && !q[0].we) s_dat_i = mem[q[0].adr];
        else                   s_dat_i = 16'($urandom);
        @(negedge clk);

        full  = (q.size() == MAX_OUT);
        e_cyc = draining; e_stb = 1'b0; e_we = 1'b0; e_adr = 16'h0; e_dat = 16'h0;
        for (int n = 0; n < 2; n++) begin
            e_ack[n] = 1'b0; e_stl[n] = 1'b1; e_do[n] = hold[n];
        end
        if (owner >= 0) begin
            e_cyc = m_cyc[owner] || (q.size() != 0);
            e_stb = m_cyc[owner] && m_stb[owner] && !full;
            e_we  = m_we[owner];
            e_adr = m_adr[owner];
            e_dat = m_dati[owner];
            e_stl[owner] = s_stall || full;
            e_ack[owner] = s_ack;
            e_do[owner]  = s_dat_i;
        end
        chk("s_cyc", s_cyc, e_cyc);
        chk("s_stb", s_stb, e_stb);
        chk("s_we", s_we, e_we);
        chk("s_adr", s_adr, e_adr);
        chk("s_dat_o", s_dat_o, e_dat);
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("m%0d_ack", n), m_ack[n], e_ack[n]);
            chk($sformatf("m%0d_stall", n), m_stall[n], e_stl[n]);
            chk($sformatf("m%0d_dat_o", n), m_dato[n], e_do[n]);
            if (e_ack[n] && !q[0].we) chk($sformatf("m%0d_rdata", n), m_dato[n], mem[q[0].adr]);
            if (m_ack[n] === 1'b1) begin
                ack_cnt[n]++; ack_log.push_back(n); last_ack_dat[n] = m_dato[n];
            end
        end

        acc    = e_stb && !s_stall;
        for (int n = 0; n < 2; n++) begin
            g_acc[n] = acc && (owner == n);
            g_ack[n] = e_ack[n];
        end
        sv_rst = rst; sv_ack = s_ack; sv_dat = s_dat_i;
        r.we = e_we; r.adr = e_adr; r.dat = e_dat;

        @(posedge clk);
        if (sv_rst) begin
            owner = -1; draining = 1'b0; last = 1'b1; q.delete();
            hold[0] = 16'h0; hold[1] = 16'h0;
        end else begin
            if (owner >= 0) hold[owner] = sv_dat;
            if (owner < 0 && !draining) begin
                if (m_cyc[0] && (!m_cyc[1] || last)) begin owner = 0; last = 1'b0; end
                else if (m_cyc[1])                   begin owner = 1; last = 1'b1; end
            end else if (owner >= 0) begin
                left = q.size() + int'(acc) - int'(sv_ack);
                if (!m_cyc[owner]) begin draining = (left != 0); owner = -1; end
            end else begin
                if (q.size() - int'(sv_ack) == 0) draining = 1'b0;
            end
            if (sv_ack) begin
                if (q[0].we) mem[q[0].adr] = q[0].dat;
                void'(q.pop_front());
            end
            if (acc) q.push_back(r);
        end
        #1;
    endtask

    task automatic run(input int max_cyc, input bit until_done);
        bit done;
        int i;
        done = 1'b0; i = 0;
        while (!(until_done && done) && i < max_cyc) begin
            if (rand_mode) begin
                for (int n = 0; n < 2; n++) begin
                    if (a_tx[n] == 0 && !a_gap[n] && $urandom_range(3) == 0)
                        start(n, 1, int'($urandom_range(1, 4)), 16'($urandom),
                              bit'($urandom_range(1)), ($urandom_range(9) == 0) ? 1 : 0);
                end
            end
            drive_agents();
            cycle();
            update_agents();
            done = (a_tx[0] == 0) && (a_tx[1] == 0) && !a_gap[0] && !a_gap[1] &&
                   (owner < 0) && !draining && (q.size() == 0);
            i++;
        end
        if (until_done) chk("timeout", done, 1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = rom_f(16'(i));
        rst = 1'b1; stall_pct = 0; ack_pct = 100; rand_mode = 1'b0;
        s_ack = 1'b0; s_stall = 1'b0; s_dat_i = 16'h0;
        for (int n = 0; n < 2; n++) begin
            start(n, 0, 0, 16'h0, 1'b0, 0);
            ack_cnt[n] = 0; last_ack_dat[n] = 16'h0; hold[n] = 16'h0;
        end
        owner = -1; draining = 1'b0; last = 1'b1;
        drive_agents();
        @(posedge clk); #1;

        // reset held for three cycles
        repeat (3) cycle();
        rst = 1'b0;

        // single read from m0
        start(0, 1, 1, 16'h0010, 1'b0, 0);
        run(50, 1);
        chk("t2_rdata", last_ack_dat[0], rom_f(16'h0010));
        chk("t2_m0_acks", ack_cnt[0], 1);
        chk("t2_m1_acks", ack_cnt[1], 0);

        // four back-to-back reads
        start(0, 1, 4, 16'h0000, 1'b0, 0);
        run(50, 1);
        chk("t3_m0_acks", ack_cnt[0], 5);
        chk("t3_rdata", last_ack_dat[0], rom_f(16'h0003));

        // slave withholds ACK until the outstanding limit is reached
        ack_pct = 0;
        start(0, 1, 3, 16'h0100, 1'b0, 0);
        run(6, 0);
        chk("t4_stall", m_stall[0], 1);
        chk("t4_stb", s_stb, 0);
        ack_pct = 100;
        run(50, 1);
        chk("t4_m0_acks", ack_cnt[0], 8);

        // round robin from reset
        rst = 1'b1; drive_agents(); cycle(); rst = 1'b0;
        ack_log.delete();
        start(0, 2, 1, 16'h0020, 1'b0, 0);
        start(1, 2, 1, 16'h0030, 1'b0, 0);
        run(80, 1);
        chk("t5_count", ack_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t5_order", (i < ack_log.size()) ? ack_log[i] : 9, i % 2);

        // m1 aborts with two outstanding; m0 waits for the drain
        ack_pct = 0;
        start(1, 1, 2, 16'h0200, 1'b0, 2);
        run(6, 0);
        chk("t6_drain_cyc", s_cyc, 1);
        start(0, 1, 1, 16'h0300, 1'b0, 0);
        run(4, 0);
        chk("t6_m0_held", m_stall[0], 1);
        ack_pct = 100;
        run(50, 1);

        // same abort, but reset hits during the drain
        ack_pct = 0;
        start(1, 1, 2, 16'h0400, 1'b1, 2);
        run(6, 0);
        rst = 1'b1; drive_agents(); cycle(); rst = 1'b0;
        chk("t6b_idle_cyc", s_cyc, 0);
        ack_pct = 100;
        run(2, 0);

        // random mixed traffic
        rand_mode = 1'b1; stall_pct = 25; ack_pct = 60;
        run(400, 0);
        rand_mode = 1'b0;
        run(400, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
